pe_ctrl: RTL and testbench

Sequencer that drives one PE array: 16 compute units, a feedback path and an adder tree. It accepts a command plus two 16-lane operand vectors over a valid/ready handshake, then drives the PE's operand buses and its control lines `Sel_cu`, `Is_save_cu_out`, `Sel_cu_go_back` and `Sel_adder` in the required order. It samples the PE result (per-lane vector or reduced total) and returns it over a second valid/ready handshake. It sits between the layer scheduler and the PE, as the initiator for the PE's control protocol.

---
 rtl/pe_ctrl_pkg.sv | 35 +++
 rtl/pe_ctrl_resbuf.sv | 54 +++++
 rtl/pe_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_pe_ctrl.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_ctrl_pkg.sv
// Shared types and PE control codes for the pe_ctrl sequencer.
// PE_CTRL_PERF_EN (optional, in pe_ctrl) adds busy/command performance counters.
package pe_ctrl_pkg;

   localparam int unsigned OP_W   = 2;
   localparam int unsigned PASS_W = 4;
   localparam int unsigned CNT_W  = 4;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_COMPUTE  = 3'd1,
      ST_FEEDBACK = 3'd2,
      ST_CAPTURE  = 3'd3,
      ST_EMIT     = 3'd4,
      ST_SAMPLE   = 3'd5,
      ST_RESP     = 3'd6
   } state_e;

   localparam logic [1:0] GB_NONE  = 2'b00;
   localparam logic [1:0] GB_PAR   = 2'b01;
   localparam logic [1:0] GB_CAPT  = 2'b10;
   localparam logic [1:0] GB_IN    = 2'b11;

   localparam logic [1:0] AD_NONE  = 2'b00;
   localparam logic [1:0] AD_LANES = 2'b01;
   localparam logic [1:0] AD_TREE  = 2'b10;

   // Latched command fields that steer the PE control lines.
   typedef struct packed {
      logic [OP_W-1:0] op;
      logic            fb_par;
      logic            reduce;
   } cmd_t;

endpackage

// File: rtl/pe_ctrl_resbuf.sv
// Result register: captures the PE total or lane vector and holds it until accepted.
module pe_ctrl_resbuf
   import pe_ctrl_pkg::*;
#(
   parameter int unsigned DW = 32,
   parameter int unsigned VW = 512
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          load_i,
   input  logic          reduce_i,
   input  logic [DW-1:0] total_i,
   input  logic [VW-1:0] vec_i,
   input  logic          ready_i,
   output logic          valid_o,
   output logic [DW-1:0] total_o,
   output logic [VW-1:0] vec_o
);

   logic          valid_q, valid_d;
   logic [DW-1:0] total_q, total_d;
   logic [VW-1:0] vec_q,   vec_d;

   // The unused result flavour is zeroed so the consumer never sees stale data.
   always_comb begin
      valid_d = valid_q;
      total_d = total_q;
      vec_d   = vec_q;
      if (load_i) begin
         valid_d = 1'b1;
         total_d = reduce_i ? total_i : '0;
         vec_d   = reduce_i ? '0 : vec_i;
      end else if (valid_q && ready_i) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         valid_q <= 1'b0;
         total_q <= '0;
         vec_q   <= '0;
      end else begin
         valid_q <= valid_d;
         total_q <= total_d;
         vec_q   <= vec_d;
      end
   end

   assign valid_o = valid_q;
   assign total_o = total_q;
   assign vec_o   = vec_q;

endmodule

// File: rtl/pe_ctrl.sv
// Sequencer for one PE array: command in, PE control sequence, result out.
// Define PE_CTRL_PERF_EN to add the perf_busy / perf_cmds counters.
module pe_ctrl
   import pe_ctrl_pkg::*;
#(
   parameter int unsigned CU_LAT = 1,
   parameter int unsigned LANES  = 16,
   parameter int unsigned DW     = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                cmd_valid,
   output logic                cmd_ready,
   input  logic [OP_W-1:0]     cmd_op,
   input  logic [PASS_W-1:0]   cmd_passes,
   input  logic                cmd_fb_par,
   input  logic                cmd_reduce,
   input  logic [LANES*DW-1:0] in_vec,
   input  logic [LANES*DW-1:0] par_vec,
   output logic [LANES*DW-1:0] pe_in,
   output logic [LANES*DW-1:0] pe_par,
   output logic [OP_W-1:0]     pe_sel_cu,
   output logic                pe_is_save,
   output logic [1:0]          pe_sel_go_back,
   output logic [1:0]          pe_sel_adder,
   input  logic [DW-1:0]       pe_out_total,
   input  logic [LANES*DW-1:0] pe_out_vec,
   output logic                res_valid,
   input  logic                res_ready,
   output logic [DW-1:0]       res_total,
   output logic [LANES*DW-1:0] res_vec
`ifdef PE_CTRL_PERF_EN
   ,
   output logic [31:0]         perf_busy,
   output logic [15:0]         perf_cmds
`endif
);

   localparam int unsigned VW = LANES * DW;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(CU_LAT - 1);

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [PASS_W-1:0] passes_q, passes_d;
   cmd_t              cmd_q, cmd_d;
   logic [VW-1:0]     in_q, in_d, par_q, par_d;
   logic              ready_q, ready_d;
   logic [OP_W-1:0]   sel_cu_q, sel_cu_d;
   logic              is_save_q, is_save_d;
   logic [1:0]        gb_q, gb_d;
   logic [1:0]        adder_q, adder_d;
   logic              accept;

   assign accept = (state_q == ST_IDLE) && cmd_valid;

   // Next state, then control lines decoded from the next state so they register in step.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      passes_d  = passes_q;
      cmd_d     = cmd_q;
      in_d      = in_q;
      par_d     = par_q;
      ready_d   = 1'b0;
      sel_cu_d  = '0;
      is_save_d = 1'b0;
      gb_d      = GB_NONE;
      adder_d   = AD_NONE;

      unique case (state_q)
         ST_IDLE: begin
            if (accept) begin
               state_d  = ST_COMPUTE;
               cnt_d    = CNT_LOAD;
               passes_d = cmd_passes;
               cmd_d    = '{op: cmd_op, fb_par: cmd_fb_par, reduce: cmd_reduce};
               in_d     = in_vec;
               par_d    = par_vec;
            end
         end
         ST_COMPUTE: begin
            if (cnt_q == '0) begin
               state_d = (passes_q != '0) ? ST_FEEDBACK : ST_CAPTURE;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         ST_FEEDBACK: begin
            passes_d = passes_q - PASS_W'(1);
            cnt_d    = CNT_LOAD;
            state_d  = ST_COMPUTE;
         end
         ST_CAPTURE: state_d = ST_EMIT;
         ST_EMIT:    state_d = ST_SAMPLE;
         ST_SAMPLE:  state_d = ST_RESP;
         ST_RESP: begin
            if (res_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      unique case (state_d)
         ST_IDLE:     ready_d  = 1'b1;
         ST_COMPUTE:  sel_cu_d = cmd_d.op;
         ST_FEEDBACK: begin
            is_save_d = 1'b1;
            gb_d      = cmd_d.fb_par ? GB_PAR : GB_IN;
         end
         ST_CAPTURE:  gb_d     = GB_CAPT;
         ST_EMIT:     adder_d  = cmd_d.reduce ? AD_TREE : AD_LANES;
         default:     ready_d  = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         passes_q  <= '0;
         cmd_q     <= '0;
         in_q      <= '0;
         par_q     <= '0;
         ready_q   <= 1'b1;
         sel_cu_q  <= '0;
         is_save_q <= 1'b0;
         gb_q      <= GB_NONE;
         adder_q   <= AD_NONE;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         passes_q  <= passes_d;
         cmd_q     <= cmd_d;
         in_q      <= in_d;
         par_q     <= par_d;
         ready_q   <= ready_d;
         sel_cu_q  <= sel_cu_d;
         is_save_q <= is_save_d;
         gb_q      <= gb_d;
         adder_q   <= adder_d;
      end
   end

   assign cmd_ready      = ready_q;
   assign pe_in          = in_q;
   assign pe_par         = par_q;
   assign pe_sel_cu      = sel_cu_q;
   assign pe_is_save     = is_save_q;
   assign pe_sel_go_back = gb_q;
   assign pe_sel_adder   = adder_q;

   pe_ctrl_resbuf #(
      .DW (DW),
      .VW (VW)
   ) u_resbuf (
      .clk      (clk),
      .rst      (rst),
      .load_i   (state_q == ST_SAMPLE),
      .reduce_i (cmd_q.reduce),
      .total_i  (pe_out_total),
      .vec_i    (pe_out_vec),
      .ready_i  (res_ready),
      .valid_o  (res_valid),
      .total_o  (res_total),
      .vec_o    (res_vec)
   );

`ifdef PE_CTRL_PERF_EN
   logic [31:0] busy_q;
   logic [15:0] cmds_q;

   // Free-running counters; wrap naturally.
   always_ff @(posedge clk) begin
      if (!rst) begin
         busy_q <= '0;
         cmds_q <= '0;
      end else begin
         if (state_q != ST_IDLE) busy_q <= busy_q + 32'd1;
         if (accept)             cmds_q <= cmds_q + 16'd1;
      end
   end

   assign perf_busy = busy_q;
   assign perf_cmds = cmds_q;
`endif

endmodule

// File: tb/tb_pe_ctrl.sv
// Directed bench for pe_ctrl: two instances (CU_LAT=1 and CU_LAT=2) share one stimulus stream.
module tb_pe_ctrl;
   import pe_ctrl_pkg::*;

   localparam logic [31:0] STUB_TOTAL = 32'h0000_00AB;

   logic         clk = 1'b0;
   logic         rst;
   logic         cmd_valid;
   logic [1:0]   cmd_op;
   logic [3:0]   cmd_passes;
   logic         cmd_fb_par;
   logic         cmd_reduce;
   logic [511:0] in_vec;
   logic [511:0] par_vec;
   logic         res_ready;
   logic [511:0] stub_vec;

   logic         cmd_ready [2];
   logic [511:0] pe_in     [2];
   logic [511:0] pe_par    [2];
   logic [1:0]   sel_cu    [2];
   logic         is_save   [2];
   logic [1:0]   gb        [2];
   logic [1:0]   add       [2];
   logic [31:0]  out_total [2];
   logic [511:0] out_vec   [2];
   logic         res_valid [2];
   logic [31:0]  res_total [2];
   logic [511:0] res_vec   [2];
`ifdef PE_CTRL_PERF_EN
   logic [31:0]  perf_busy [2];
   logic [15:0]  perf_cmds [2];
`endif

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 2; g++) begin : g_dut
      logic emit_q = 1'b0;

      // PE stub: result is only valid in the cycle after the adder select was driven.
      always_ff @(posedge clk) emit_q <= (add[g] != AD_NONE);
      assign out_total[g] = emit_q ? STUB_TOTAL : 32'h0;
      assign out_vec[g]   = emit_q ? stub_vec : '0;

      pe_ctrl #(.CU_LAT(g + 1)) u_dut (
         .clk            (clk),
         .rst            (rst),
         .cmd_valid      (cmd_valid),
         .cmd_ready      (cmd_ready[g]),
         .cmd_op         (cmd_op),
         .cmd_passes     (cmd_passes),
         .cmd_fb_par     (cmd_fb_par),
         .cmd_reduce     (cmd_reduce),
         .in_vec         (in_vec),
         .par_vec        (par_vec),
         .pe_in          (pe_in[g]),
         .pe_par         (pe_par[g]),
         .pe_sel_cu      (sel_cu[g]),
         .pe_is_save     (is_save[g]),
         .pe_sel_go_back (gb[g]),
         .pe_sel_adder   (add[g]),
         .pe_out_total   (out_total[g]),
         .pe_out_vec     (out_vec[g]),
         .res_valid      (res_valid[g]),
         .res_ready      (res_ready),
         .res_total      (res_total[g]),
         .res_vec        (res_vec[g])
`ifdef PE_CTRL_PERF_EN
         ,
         .perf_busy      (perf_busy[g]),
         .perf_cmds      (perf_cmds[g])
`endif
      );
   end

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   int         lat [2];
   int         saves, last_save, bad_gap, bad_gb, ready_hi, vec_chg, capt, adds;
   logic [1:0] sel0;

   // Issue one command, hold res_ready low for 'hold' cycles while observing, then release.
   task automatic run_cmd(input logic [1:0] op, input logic [3:0] passes, input logic fb,
                          input logic red, input int hold);
      logic [511:0] held, vin;
      logic [1:0]   exp_gb, exp_add;
      vin     = in_vec;
      held    = '0;
      exp_gb  = fb ? GB_PAR : GB_IN;
      exp_add = red ? AD_TREE : AD_LANES;
      lat[0] = -1; lat[1] = -1;
      saves = 0; last_save = -1; bad_gap = 0; bad_gb = 0;
      ready_hi = 0; vec_chg = 0; capt = 0; adds = 0;
      cmd_op = op; cmd_passes = passes; cmd_fb_par = fb; cmd_reduce = red;
      cmd_valid = 1'b1;
      cycle();
      cmd_valid = 1'b0;
      sel0 = sel_cu[0];
      for (int k = 1; k <= hold; k++) begin
         cycle();
         for (int i = 0; i < 2; i++) if (res_valid[i] && lat[i] < 0) lat[i] = k;
         if (cmd_ready[0] || cmd_ready[1]) ready_hi++;
         if (is_save[1]) begin
            saves++;
            if (gb[1] != exp_gb) bad_gb++;
            if (last_save >= 0 && k - last_save != 3) bad_gap++;
            last_save = k;
         end
         if (gb[0] == GB_CAPT) capt++;
         if (add[0] == exp_add) adds++;
         if (lat[1] >= 0) begin
            if (k == lat[1]) held = res_vec[1];
            else if (res_vec[1] !== held) vec_chg++;
         end
         if (k == 3) begin cmd_valid = 1'b1; in_vec = '1; end
         if (k == 4) begin cmd_valid = 1'b0; in_vec = vin; end
      end
      res_ready = 1'b1;
      cycle();
      res_ready = 1'b0;
   endtask

   initial begin
      int rv_cnt, rdy_lo, first_rv;
      logic [1:0] sel_k6;
      logic rdy_k5;
      for (int k = 0; k < 16; k++) stub_vec[32*k +: 32] = 32'h1100_0000 + 32'(k);
      stub_vec[5*32 +: 32] = 32'hDEAD_BEEF;
      rst = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_passes = 4'd0;
      cmd_fb_par = 1'b0; cmd_reduce = 1'b0; res_ready = 1'b0;
      in_vec  = {16{32'h0102_0304}};
      par_vec = {16{32'hCAFE_0000}};
      cycle(); cycle();

      // Reset state
      for (int i = 0; i < 2; i++) begin
         chk("rst_cmd_ready", 512'(cmd_ready[i]), 512'(1));
         chk("rst_res_valid", 512'(res_valid[i]), 512'(0));
         chk("rst_pe_in", pe_in[i], '0);
         chk("rst_pe_ctl", 512'({sel_cu[i], is_save[i], gb[i], add[i]}), 512'(0));
         chk("rst_res", 512'({res_total[i], res_vec[i]}), '0);
      end
      rst = 1'b1;
      cycle();

      // No feedback, reduced
      run_cmd(2'b01, 4'd0, 1'b0, 1'b1, 12);
      chk("lat_p0_cu1", 512'(lat[0]), 512'(4));
      chk("lat_p0_cu2", 512'(lat[1]), 512'(5));
      chk("sel_cu_op01", 512'(sel0), 512'(2'b01));
      chk("total_red", 512'(res_total[0]), 512'(32'h0000_00AB));
      chk("vec_red_zero", res_vec[0], '0);
      chk("capt_pulses", 512'(capt), 512'(1));
      chk("adder_tree", 512'(adds), 512'(1));
      chk("busy_ready", 512'(ready_hi), 512'(0));
      chk("no_saves", 512'(saves), 512'(0));
      chk("rel_valid", 512'({res_valid[0], res_valid[1]}), 512'(0));
      chk("rel_ready", 512'({cmd_ready[0], cmd_ready[1]}), 512'(2'b11));
      chk("pe_in_held", pe_in[1], in_vec);
      chk("pe_par_held", pe_par[1], par_vec);

      // Feedback into Par, per-lane result held for a long time
      in_vec  = {16{32'h5555_0001}};
      par_vec = {16{32'h0BAD_F00D}};
      run_cmd(2'b10, 4'd2, 1'b1, 1'b0, 25);
      chk("lat_p2_cu2", 512'(lat[1]), 512'(11));
      chk("lat_p2_cu1", 512'(lat[0]), 512'(8));
      chk("par_saves", 512'(saves), 512'(2));
      chk("par_save_gb", 512'(bad_gb), 512'(0));
      chk("save_gap", 512'(bad_gap), 512'(0));
      chk("lane5", 512'(res_vec[1][5*32 +: 32]), 512'(32'hDEAD_BEEF));
      chk("vec_full", res_vec[1], stub_vec);
      chk("total_lanes_zero", 512'(res_total[1]), 512'(0));
      chk("vec_stable", 512'(vec_chg), 512'(0));
      chk("held_ready", 512'(ready_hi), 512'(0));
      chk("adder_lanes", 512'(adds), 512'(1));
      chk("sel_cu_op10", 512'(sel0), 512'(2'b10));
      chk("pe_in_ignored", pe_in[1], in_vec);

      // Feedback into In
      run_cmd(2'b11, 4'd1, 1'b0, 1'b1, 12);
      chk("lat_p1_cu1", 512'(lat[0]), 512'(6));
      chk("lat_p1_cu2", 512'(lat[1]), 512'(8));
      chk("in_saves", 512'(saves), 512'(1));
      chk("in_save_gb", 512'(bad_gb), 512'(0));

      // Reset mid-command
      cmd_op = 2'b01; cmd_passes = 4'd3; cmd_reduce = 1'b1; cmd_valid = 1'b1;
      cycle();
      cmd_valid = 1'b0;
      chk("mid_in_compute", 512'(sel_cu[0]), 512'(2'b01));
      rst = 1'b0;
      cycle();
      rst = 1'b1;
      chk("mid_ctl_zero", 512'({sel_cu[0], is_save[0], gb[0], add[0], res_valid[0]}), 512'(0));
      chk("mid_pe_in_zero", pe_in[0], '0);
      chk("mid_ready", 512'(cmd_ready[0]), 512'(1));
      res_ready = 1'b1;
      rv_cnt = 0; rdy_lo = 0;
      for (int k = 0; k < 20; k++) begin
         cycle();
         if (res_valid[0] || res_valid[1]) rv_cnt++;
         if (!cmd_ready[0] || !cmd_ready[1]) rdy_lo++;
      end
      chk("mid_no_resp", 512'(rv_cnt), 512'(0));
      chk("mid_stays_idle", 512'(rdy_lo), 512'(0));

      // Back-to-back with res_ready tied high
      cmd_op = 2'b01; cmd_passes = 4'd0; cmd_reduce = 1'b1; cmd_valid = 1'b1;
      cycle();
      sel0 = sel_cu[0];
      cmd_op = 2'b10;
      rv_cnt = 0; first_rv = -1; sel_k6 = 2'b00; rdy_k5 = 1'b0;
      for (int k = 1; k <= 20; k++) begin
         cycle();
         if (res_valid[0]) begin
            rv_cnt++;
            if (first_rv < 0) first_rv = k;
         end
         if (k == 5) rdy_k5 = cmd_ready[0];
         if (k == 6) begin sel_k6 = sel_cu[0]; cmd_valid = 1'b0; end
      end
      chk("b2b_first_op", 512'(sel0), 512'(2'b01));
      chk("b2b_first_rv", 512'(first_rv), 512'(4));
      chk("b2b_ready_after", 512'(rdy_k5), 512'(1));
      chk("b2b_second_op", 512'(sel_k6), 512'(2'b10));
      chk("b2b_resp_cycles", 512'(rv_cnt), 512'(2));
      res_ready = 1'b0;

`ifdef PE_CTRL_PERF_EN
      rst = 1'b0;
      cycle();
      rst = 1'b1;
      res_ready = 1'b1;
      cmd_passes = 4'd0;
      for (int n = 0; n < 3; n++) begin
         cmd_valid = 1'b1;
         cycle();
         cmd_valid = 1'b0;
         for (int k = 0; k < 7; k++) cycle();
      end
      chk("perf_cmds", 512'(perf_cmds[0]), 512'(3));
      chk("perf_busy", 512'(perf_busy[0]), 512'(15));
      res_ready = 1'b0;
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
